// File: rtl/elevador_pkg.sv
// Shared elevator definitions: default button count and the bit index
// of every call/car button in the button vectors.
package elevador_pkg;

  localparam int N_BOTONES_DEF = 10;

  // Hall calls (floor + direction) followed by car buttons
  localparam int BTN_P1_ARRIBA = 0;
  localparam int BTN_P2_ARRIBA = 1;
  localparam int BTN_P2_ABAJO  = 2;
  localparam int BTN_P3_ARRIBA = 3;
  localparam int BTN_P3_ABAJO  = 4;
  localparam int BTN_P4_ABAJO  = 5;
  localparam int BTN_P1_CABINA = 6;
  localparam int BTN_P2_CABINA = 7;
  localparam int BTN_P3_CABINA = 8;
  localparam int BTN_P4_CABINA = 9;

  // Width of a saturating/terminal counter able to hold the value n
  function automatic int ancho_contador(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// Single button channel: 2-flop synchronizer, debounce counter with a
// stable-state bit, registered level and press pulse.
// Optional stuck-button detection is enabled by defining STUCK_DETECT_EN.
module antirrebote_canal
  import elevador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_raw,
  output logic boton,
  output logic pulso,
  output logic atascado
);

  localparam int CW = ancho_contador(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          estable_r;
  logic [CW-1:0] cnt_r;
  logic          boton_r;
  logic          pulso_r;
  logic          boton_nxt_s;

  // Bring the asynchronous raw level into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= boton_raw;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it differs from the stable state for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estable_r <= 1'b0;
      cnt_r     <= '0;
    end else if (sync2_r == estable_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_MAX) begin
      estable_r <= sync2_r;
      cnt_r     <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int HW = ancho_contador(STUCK_CYCLES);
  localparam logic [HW-1:0] HELD_MAX = HW'(STUCK_CYCLES);
  localparam logic [HW-1:0] HELD_PRE = HW'(STUCK_CYCLES - 1);

  logic [HW-1:0] held_r;
  logic          atascado_r;

  // Count held cycles; flag the channel once the count saturates, clear on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r     <= '0;
      atascado_r <= 1'b0;
    end else if (!estable_r) begin
      held_r     <= '0;
      atascado_r <= 1'b0;
    end else if (held_r != HELD_MAX) begin
      held_r     <= held_r + HW'(1);
      atascado_r <= atascado_r | (held_r == HELD_PRE);
    end else begin
      atascado_r <= 1'b1;
    end
  end

  // A stuck button is masked out of the debounced level
  always_comb begin
    boton_nxt_s = estable_r & ~atascado_r;
  end

  assign atascado = atascado_r;
`else
  // Debounced level follows the stable state directly
  always_comb begin
    boton_nxt_s = estable_r;
  end

  assign atascado = 1'b0;
`endif

  // Registered level and one-cycle pulse on its rising edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boton_r <= 1'b0;
      pulso_r <= 1'b0;
    end else begin
      boton_r <= boton_nxt_s;
      pulso_r <= boton_nxt_s & ~boton_r;
    end
  end

  assign boton = boton_r;
  assign pulso = pulso_r;

endmodule

// File: rtl/botones_antirrebote.sv
// Debouncer for the elevator button bank: one independent channel per
// button. Define STUCK_DETECT_EN to enable per-channel stuck detection.
module botones_antirrebote
  import elevador_pkg::*;
#(
  parameter int N_BOTONES       = N_BOTONES_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BOTONES-1:0] botones_raw,
  output logic [N_BOTONES-1:0] botones,
  output logic [N_BOTONES-1:0] pulso,
  output logic [N_BOTONES-1:0] atascado
);

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
    antirrebote_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_canal (
      .clk       (clk),
      .rst_n     (rst_n),
      .boton_raw (botones_raw[i]),
      .boton     (botones[i]),
      .pulso     (pulso[i]),
      .atascado  (atascado[i])
    );
  end

endmodule

// File: tb/tb_botones_antirrebote.sv
// Directed bench for botones_antirrebote with DEBOUNCE_CYCLES=4, STUCK_CYCLES=32.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_botones_antirrebote;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] botones_raw;
  logic [9:0] botones;
  logic [9:0] pulso;
  logic [9:0] atascado;

  int checks = 0;
  int errors = 0;

  botones_antirrebote #(
    .N_BOTONES       (10),
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .botones_raw (botones_raw),
    .botones     (botones),
    .pulso       (pulso),
    .atascado    (atascado)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [9:0] eb, input logic [9:0] ep);
    check({tag, "_botones"}, botones, eb);
    check({tag, "_pulso"}, pulso, ep);
    check({tag, "_atascado"}, atascado, 10'h000);
  endtask

  initial begin
    // Reset with every raw button pressed
    rst_n       = 1'b0;
    botones_raw = 10'h3FF;
    #1;
    check_out("reset_t0", 10'h000, 10'h000);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_out("reset_hold", 10'h000, 10'h000);
    end
    botones_raw = 10'h000;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check_out("post_reset", 10'h000, 10'h000);

    // Clean press on bit 3: visible exactly 6 edges after the first sampling edge
    botones_raw = 10'h008;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check_out("press3_wait", 10'h000, 10'h000);
    end
    tick(1);
    check_out("press3_edge", 10'h008, 10'h008);
    tick(1);
    check_out("press3_hold", 10'h008, 10'h000);
    botones_raw = 10'h000;
    tick(6);
    check_out("release3_wait", 10'h008, 10'h000);
    tick(1);
    check_out("release3_done", 10'h000, 10'h000);
    tick(1);
    check_out("release3_nopulse", 10'h000, 10'h000);

    // Bounce on bit 0: 1,0,1,0 every 2 cycles then steady 1
    for (int b = 0; b < 4; b++) begin
      botones_raw = (b % 2 == 0) ? 10'h001 : 10'h000;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        check_out("bounce0_glitch", 10'h000, 10'h000);
      end
    end
    botones_raw = 10'h001;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check_out("bounce0_wait", 10'h000, 10'h000);
    end
    tick(1);
    check_out("bounce0_edge", 10'h001, 10'h001);
    tick(1);
    check_out("bounce0_hold", 10'h001, 10'h000);
    botones_raw = 10'h000;
    tick(8);
    check_out("bounce0_release", 10'h000, 10'h000);

    // Bits 1 and 9 together, bit 9 dropped after 3 cycles
    botones_raw = 10'h202;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (k == 2) botones_raw = 10'h002;
      check_out("simul_wait", 10'h000, 10'h000);
    end
    tick(1);
    check_out("simul_edge", 10'h002, 10'h002);
    tick(1);
    check_out("simul_hold", 10'h002, 10'h000);
    tick(4);
    check_out("simul_bit9_quiet", 10'h002, 10'h000);
    botones_raw = 10'h000;
    tick(8);
    check_out("simul_release", 10'h000, 10'h000);

    // Reset in the middle of debouncing bit 5
    botones_raw = 10'h020;
    tick(3);
    rst_n = 1'b0;
    #1;
    check_out("midrst_assert", 10'h000, 10'h000);
    tick(2);
    check_out("midrst_hold", 10'h000, 10'h000);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check_out("midrst_wait", 10'h000, 10'h000);
    end
    tick(1);
    check_out("midrst_edge", 10'h020, 10'h020);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_out("midrst_single_pulse", 10'h020, 10'h000);
    end
    botones_raw = 10'h000;
    tick(8);
    check_out("midrst_release", 10'h000, 10'h000);

    // Bit 7 held for 40 cycles
    botones_raw = 10'h080;
    tick(7);
    check_out("stuck7_press", 10'h080, 10'h080);
    tick(31);
`ifdef STUCK_DETECT_EN
    check("stuck7_flag", atascado, 10'h080);
    check("stuck7_still_on", botones, 10'h080);
    tick(1);
    check("stuck7_forced_off", botones, 10'h000);
    check("stuck7_no_pulse", pulso, 10'h000);
    check("stuck7_flag_hold", atascado, 10'h080);
    tick(1);
    botones_raw = 10'h000;
    tick(8);
    check_out("stuck7_cleared", 10'h000, 10'h000);
    botones_raw = 10'h080;
    tick(7);
    check_out("stuck7_repress", 10'h080, 10'h080);
`else
    check_out("stuck7_off_a", 10'h080, 10'h000);
    tick(2);
    check_out("stuck7_off_b", 10'h080, 10'h000);
    botones_raw = 10'h000;
    tick(8);
    check_out("stuck7_off_release", 10'h000, 10'h000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/botones_antirrebote.md
BOTONES_ANTIRREBOTE -- requirements
Module: botones_antirrebote

Interface
REQ-001 Parameter N_BOTONES, default 10, number of button channels; bit order matches the elevator button encoding (0: floor 1 up ... 9: floor 4 car).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles required to accept a level change; legal range 2..65535.
REQ-003 Parameter STUCK_CYCLES, default 1024, number of held cycles after which a pressed button is declared stuck; used only with STUCK_DETECT_EN.
REQ-004 clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 botones_raw  input  N_BOTONES  raw mechanical button levels, asynchronous to clk, 1 = pressed.
REQ-007 botones  output  N_BOTONES  debounced, registered level per button; drives the request registrar.
REQ-008 pulso  output  N_BOTONES  one-cycle pulse per button on accepted press (0->1 of botones).
REQ-009 atascado  output  N_BOTONES  stuck-button flag per channel; constant 0 without STUCK_DETECT_EN.

Function
REQ-010 Each botones_raw bit shall pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel shall hold a stable-state bit and a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-012 Synchronized value equal to stable state: counter cleared to 0 that cycle.
REQ-013 Synchronized value different from stable state: counter increments by 1; on the cycle the counter equals DEBOUNCE_CYCLES-1, stable state takes the synchronized value and the counter clears.
REQ-014 A raw pulse or glitch shorter than DEBOUNCE_CYCLES clk cycles (after synchronization) shall produce no change on botones or pulso.
REQ-015 Latency: a clean raw edge held indefinitely appears on botones exactly 2+DEBOUNCE_CYCLES cycles after the first sampling clock edge that sees it.
REQ-016 The counter shall never wrap; it clears on acceptance or on return to stable value.
REQ-017 pulso bit shall be 1 for exactly one cycle, the cycle in which botones bit first reads 1; no pulse on release.
REQ-018 Channels are independent; simultaneous changes on any subset of bits shall each be accepted on their own schedule with no interaction.
REQ-019 botones and pulso shall be driven directly from flops (no combinational path from botones_raw).

Reset
REQ-020 While rst_n = 0: synchronizer flops, stable state, counters, botones, pulso, atascado all 0.
REQ-021 Reset asserted mid-debounce shall discard the partial count; after release, a still-pressed button is accepted as a new press with full latency and one pulse.
REQ-022 Reset deassertion shall be synchronized externally; no reset-release pulse on pulso.

Configuration
REQ-023 Macro STUCK_DETECT_EN defined: per-channel held counter (width clog2(STUCK_CYCLES)+1) counts while stable state = 1, saturating at STUCK_CYCLES.
REQ-024 With STUCK_DETECT_EN, when held counter reaches STUCK_CYCLES, atascado bit sets and botones bit is forced 0 from the next cycle; no pulse is generated.
REQ-025 With STUCK_DETECT_EN, atascado bit and held counter clear when stable state returns to 0; next accepted press behaves normally.
REQ-026 Macro STUCK_DETECT_EN undefined: no held counters, atascado tied to 0, botones equals stable state.

Structure
REQ-027 Shared package elevador_pkg shall hold N_BOTONES default and the button index constants (BTN_P1_ARRIBA .. BTN_P4_CABINA).
REQ-028 One sub-module antirrebote_canal (single channel: synchronizer, counter, stable bit, pulse, optional stuck logic) instantiated N_BOTONES times via generate.

Verification (bench uses DEBOUNCE_CYCLES=4, STUCK_CYCLES=32)
REQ-029 Reset: rst_n=0 with botones_raw=10'h3FF -> botones, pulso, atascado = 0 throughout reset.
REQ-030 Clean press: bit 3 rises and holds -> botones[3]=1 exactly 6 cycles later, pulso[3]=1 for that single cycle, other bits 0.
REQ-031 Bounce: bit 0 toggles 1,0,1,0 each 2 cycles then holds 1 -> single pulso[0] 6 cycles after final rise, no earlier change.
REQ-032 Simultaneous: bits 1 and 9 rise same cycle, bit 9 released after 3 cycles -> only botones[1]/pulso[1] respond.
REQ-033 Reset mid-debounce: bit 5 held, rst_n pulsed low at cycle 3 -> botones[5]=1 exactly 6 cycles after rst_n release, one pulse.
REQ-034 Stuck (macro defined): bit 7 held 40 cycles -> atascado[7]=1 and botones[7]=0 after 32 held cycles; release clears atascado[7]; undefined macro -> atascado stays 0.
